// File: rtl/kara_pkg.sv
// Shared definitions for the 6-bit Karatsuba carry-less multiplier stages:
// operand/half/product widths and the partial-product FSM state type.
package kara_pkg;

  localparam int unsigned N  = 6;
  localparam int unsigned H  = N / 2;
  localparam int unsigned PW = 2 * H - 1;

  typedef enum logic [2:0] {
    StIdle,
    StMulLo,
    StMulHi,
    StMulMid,
    StDone
  } state_e;

endpackage

// File: rtl/gf2_mul_3bit.sv
// Combinational H x H carry-less (GF(2) polynomial) multiplier with a PW-bit product.
module gf2_mul_3bit
  import kara_pkg::*;
(
  input  logic [H-1:0]  a_i,
  input  logic [H-1:0]  b_i,
  output logic [PW-1:0] p_o
);

  // Shift-and-XOR: each set bit of b contributes a shifted copy of a, no carries.
  always_comb begin
    p_o = '0;
    for (int unsigned i = 0; i < H; i++) begin
      if (b_i[i]) begin
        p_o = p_o ^ (PW'(a_i) << i);
      end
    end
  end

endmodule

// File: rtl/kara_pp_gen_6bit.sv
// Serial Karatsuba partial-product stage: one shared 3x3 carry-less multiplier
// produces pp_lo, pp_hi and the corrected pp_mid over three cycles.
module kara_pp_gen_6bit
  import kara_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] pp_lo,
  output logic [PW-1:0] pp_mid,
  output logic [PW-1:0] pp_hi
);

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [PW-1:0] pp_lo_q, pp_lo_d;
  logic [PW-1:0] pp_mid_q, pp_mid_d;
  logic [PW-1:0] pp_hi_q, pp_hi_d;
  logic          out_valid_q, out_valid_d;

  logic [H-1:0]  mul_a, mul_b;
  logic [PW-1:0] mul_p;

  gf2_mul_3bit u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    pp_lo_d  = pp_lo_q;
    pp_mid_d = pp_mid_q;
    pp_hi_d  = pp_hi_q;
    mul_a    = '0;
    mul_b    = '0;
    in_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = StMulLo;
        end
      end
      StMulLo: begin
        mul_a   = a_q[H-1:0];
        mul_b   = b_q[H-1:0];
        pp_lo_d = mul_p;
        state_d = StMulHi;
      end
      StMulHi: begin
        mul_a   = a_q[N-1:H];
        mul_b   = b_q[N-1:H];
        pp_hi_d = mul_p;
        state_d = StMulMid;
      end
      StMulMid: begin
        mul_a    = a_q[H-1:0] ^ a_q[N-1:H];
        mul_b    = b_q[H-1:0] ^ b_q[N-1:H];
        // Strip the lo/hi cross terms so downstream receives a finished middle term.
        pp_mid_d = mul_p ^ pp_lo_q ^ pp_hi_q;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            a_d     = a_in;
            b_d     = b_in;
            state_d = StMulLo;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      pp_lo_q     <= '0;
      pp_mid_q    <= '0;
      pp_hi_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pp_lo_q     <= pp_lo_d;
      pp_mid_q    <= pp_mid_d;
      pp_hi_q     <= pp_hi_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pp_lo     = pp_lo_q;
  assign pp_mid    = pp_mid_q;
  assign pp_hi     = pp_hi_q;

endmodule

// File: tb/tb_kara_pp_gen_6bit.sv
// Scoreboard bench for kara_pp_gen_6bit against an independent GF(2) Karatsuba model.
module tb_kara_pp_gen_6bit;

  typedef struct packed {
    logic [4:0] lo;
    logic [4:0] mid;
    logic [4:0] hi;
  } pp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] a_in;
  logic [5:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] pp_lo;
  logic [4:0] pp_mid;
  logic [4:0] pp_hi;

  pp_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  kara_pp_gen_6bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_lo     (pp_lo),
    .pp_mid    (pp_mid),
    .pp_hi     (pp_hi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [4:0] clmul3(input logic [2:0] x, input logic [2:0] y);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      if (y[i]) r = r ^ ({2'b00, x} << i);
    end
    return r;
  endfunction

  function automatic pp_t golden(input logic [5:0] a, input logic [5:0] b);
    pp_t p;
    p.lo  = clmul3(a[2:0], b[2:0]);
    p.hi  = clmul3(a[5:3], b[5:3]);
    p.mid = clmul3(a[2:0] ^ a[5:3], b[2:0] ^ b[5:3]) ^ p.lo ^ p.hi;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until the DUT accepts; expected result queued at the accept edge.
  task automatic send(input logic [5:0] a, input logic [5:0] b, output bit ok);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    ok       = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        sb_q.push_back(golden(a, b));
      end
      tick();
    end
    in_valid = 1'b0;
    a_in     = 6'($urandom_range(63));
    b_in     = 6'($urandom_range(63));
  endtask

  task automatic wait_out(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (out_valid) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = 6'h15;
    b_in      = 6'h2A;
    tick();
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_tests++;
    if ({pp_lo, pp_mid, pp_hi} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_pp: got %h want 0", {pp_lo, pp_mid, pp_hi});
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    bit  ok, seen;
    int  cyc;
    pp_t exp;
    out_ready = 1'b1;
    send(6'b101011, 6'b110101, ok);
    wait_out(cyc, seen);
    exp = sb_q.pop_front();
    n_tests++;
    if (!ok || !seen || cyc != 3) begin
      n_fail++;
      $display("FAIL basic_latency: got ok=%b seen=%b cyc=%0d want 1 1 3", ok, seen, cyc);
    end
    n_tests++;
    if ({pp_lo, pp_mid, pp_hi} !== {5'b01111, 5'b11011, 5'b11110}) begin
      n_fail++;
      $display("FAIL basic_const: got %b %b %b want 01111 11011 11110", pp_lo, pp_mid, pp_hi);
    end
    n_tests++;
    if ({pp_lo, pp_mid, pp_hi} !== exp) begin
      n_fail++;
      $display("FAIL basic_model: got %h want %h", {pp_lo, pp_mid, pp_hi}, exp);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_handshake: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_all_ones();
    bit  ok, seen;
    int  cyc;
    pp_t exp;
    send(6'h3F, 6'h3F, ok);
    wait_out(cyc, seen);
    exp = sb_q.pop_front();
    n_tests++;
    if (!seen || {pp_lo, pp_mid, pp_hi} !== {5'b10101, 5'b00000, 5'b10101}) begin
      n_fail++;
      $display("FAIL ones_const: got seen=%b %b %b %b want 10101 00000 10101",
               seen, pp_lo, pp_mid, pp_hi);
    end
    n_tests++;
    if ({pp_lo, pp_mid, pp_hi} !== exp) begin
      n_fail++;
      $display("FAIL ones_model: got %h want %h", {pp_lo, pp_mid, pp_hi}, exp);
    end
    tick();
  endtask

  task automatic test_zero();
    bit  ok, seen;
    int  cyc;
    pp_t exp;
    send(6'h00, 6'h2A, ok);
    wait_out(cyc, seen);
    exp = sb_q.pop_front();
    n_tests++;
    if (!seen || cyc != 3) begin
      n_fail++;
      $display("FAIL zero_latency: got seen=%b cyc=%0d want 1 3", seen, cyc);
    end
    n_tests++;
    if ({pp_lo, pp_mid, pp_hi} !== 15'd0 || exp !== 15'd0) begin
      n_fail++;
      $display("FAIL zero_pp: got %h want 0", {pp_lo, pp_mid, pp_hi});
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit  ok, seen;
    int  cyc;
    pp_t exp;
    out_ready = 1'b0;
    send(6'b110010, 6'b011101, ok);
    wait_out(cyc, seen);
    exp = sb_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got out_valid=%b in_ready=%b want 1 0",
                 i, out_valid, in_ready);
      end
      n_tests++;
      if ({pp_lo, pp_mid, pp_hi} !== exp) begin
        n_fail++;
        $display("FAIL bp_pp_%0d: got %h want %h", i, {pp_lo, pp_mid, pp_hi}, exp);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || {pp_lo, pp_mid, pp_hi} !== exp) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid=%b pp=%h want 0 %h",
               out_valid, {pp_lo, pp_mid, pp_hi}, exp);
    end
  endtask

  task automatic test_back_to_back();
    bit  ok, seen;
    int  cyc;
    pp_t exp;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in      = 6'b100111;
    b_in      = 6'b010110;
    ok        = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        sb_q.push_back(golden(a_in, b_in));
      end
      tick();
    end
    a_in = 6'b011001;
    b_in = 6'b111010;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_busy_%0d: got in_ready=%b out_valid=%b want 0 0",
                 k, in_ready, out_valid);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first_done: got out_valid=%b in_ready=%b want 1 1",
               out_valid, in_ready);
    end
    exp = sb_q.pop_front();
    n_tests++;
    if ({pp_lo, pp_mid, pp_hi} !== exp) begin
      n_fail++;
      $display("FAIL b2b_first_pp: got %h want %h", {pp_lo, pp_mid, pp_hi}, exp);
    end
    sb_q.push_back(golden(a_in, b_in));
    tick();
    in_valid = 1'b0;
    a_in     = 6'($urandom_range(63));
    b_in     = 6'($urandom_range(63));
    wait_out(cyc, seen);
    exp = sb_q.pop_front();
    n_tests++;
    if (!seen || cyc != 3) begin
      n_fail++;
      $display("FAIL b2b_interval: got seen=%b cyc=%0d want 1 3", seen, cyc);
    end
    n_tests++;
    if ({pp_lo, pp_mid, pp_hi} !== exp) begin
      n_fail++;
      $display("FAIL b2b_second_pp: got %h want %h", {pp_lo, pp_mid, pp_hi}, exp);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit  ok, seen, pulse;
    int  cyc;
    pp_t exp;
    out_ready = 1'b1;
    send(6'b011101, 6'b110011, ok);
    tick();
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    n_tests++;
    if (out_valid !== 1'b0 || {pp_lo, pp_mid, pp_hi} !== 15'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_clear: got out_valid=%b pp=%h in_ready=%b want 0 0 1",
               out_valid, {pp_lo, pp_mid, pp_hi}, in_ready);
    end
    tick();
    rst_n = 1'b1;
    pulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) pulse = 1'b1;
      tick();
    end
    n_tests++;
    if (pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_pulse: got out_valid pulse=%b want 0", pulse);
    end
    send(6'b111000, 6'b101101, ok);
    wait_out(cyc, seen);
    exp = sb_q.pop_front();
    n_tests++;
    if (!seen || {pp_lo, pp_mid, pp_hi} !== exp) begin
      n_fail++;
      $display("FAIL rstmid_next: got seen=%b pp=%h want 1 %h",
               seen, {pp_lo, pp_mid, pp_hi}, exp);
    end
    tick();
  endtask

  task automatic test_random();
    bit         ok, seen;
    int         cyc;
    pp_t        exp;
    logic [5:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 6'($urandom_range(63));
      b = 6'($urandom_range(63));
      send(a, b, ok);
      wait_out(cyc, seen);
      exp = sb_q.pop_front();
      n_tests++;
      if (!seen || cyc != 3 || {pp_lo, pp_mid, pp_hi} !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h got seen=%b cyc=%0d pp=%h want 1 3 %h",
                 i, a, b, seen, cyc, {pp_lo, pp_mid, pp_hi}, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
